fp_mul_param: RTL and testbench

Parametrised IEEE-754 binary floating-point multiplier with selectable rounding mode and exception flags. It is the next generation of the co-processor FPU multiply unit. The format width is set at elaboration through `EXP_W` and `MAN_W`, so one block serves binary16, binary32 and binary64. It keeps the FPU's strobe/acknowledge operand and result handshake, so it drops into the same co-processor datapath alongside the adder and divider.

---
 rtl/fp_mul_param.sv | 244 ++++++++++++++++++++++++
 tb/tb_fp_mul_param.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_param.sv
// fp_mul_param: multi-cycle IEEE-754 multiplier whose format is set by EXP_W/MAN_W,
// with strobe/acknowledge handshakes on both operands and on the result.
module fp_mul_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] input_a,
  input  logic         input_a_stb,
  output logic         input_a_ack,
  input  logic [1:0]   input_rm,
  input  logic [W-1:0] input_b,
  input  logic         input_b_stb,
  output logic         input_b_ack,
  output logic [W-1:0] output_z,
  output logic         output_z_stb,
  input  logic         output_z_ack,
  output logic [3:0]   output_flags
);
  localparam int M    = MAN_W + 1;
  localparam int E    = EXP_W + 2;
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  localparam logic signed [E-1:0] E_MAX = E'(BIAS);
  localparam logic signed [E-1:0] E_MIN = E'(1 - BIAS);
  localparam logic signed [E-1:0] E_ONE = E'(1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [3:0] {
    GET_A, GET_B, UNPACK, SPECIAL, NORM_A, NORM_B, MUL_0, MUL_1,
    NORM_1, NORM_2, ROUND, PACK, PUT_Z
  } state_t;

  state_t state_reg, state_next;

  logic [W-1:0]          a_reg, b_reg, z_reg;
  logic [1:0]            rm_reg;
  logic                  a_ack_reg, b_ack_reg, z_stb_reg;
  logic [3:0]            flags_reg;
  logic [M-1:0]          a_m_reg, b_m_reg, z_m_reg;
  logic signed [E-1:0]   a_e_reg, b_e_reg, z_e_reg;
  logic                  z_s_reg, g_reg, r_reg, s_reg, inexact_reg;
  logic [2*M-1:0]        prod_reg;

  // Operand classification, index 0 = A, index 1 = B
  logic [W-2:0]       op_w    [2];
  logic [EXP_W-1:0]   op_exp  [2];
  logic [MAN_W-1:0]   op_frac [2];
  logic [1:0]         op_nan, op_snan, op_inf, op_zero, op_sub;

  assign op_w[0] = a_reg[W-2:0];
  assign op_w[1] = b_reg[W-2:0];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dec
    assign op_exp[gi]  = op_w[gi][W-2:MAN_W];
    assign op_frac[gi] = op_w[gi][MAN_W-1:0];
    assign op_nan[gi]  = (&op_exp[gi]) & (|op_frac[gi]);
    assign op_snan[gi] = op_nan[gi] & ~op_frac[gi][MAN_W-1];
    assign op_inf[gi]  = (&op_exp[gi]) & ~(|op_frac[gi]);
    assign op_zero[gi] = ~(|op_exp[gi]) & ~(|op_frac[gi]);
    assign op_sub[gi]  = ~(|op_exp[gi]);
  end

  logic z_sign_w, is_special;
  assign z_sign_w   = a_reg[W-1] ^ b_reg[W-1];
  assign is_special = (|op_nan) | (|op_inf) | (|op_zero);

  logic round_inc, ovf_to_inf, pack_tiny;
  logic [EXP_W-1:0] pack_exp;
  logic [W-1:0] inf_word, max_word;

  always_comb begin
    round_inc  = 1'b0;
    ovf_to_inf = 1'b1;
    case (rm_reg)
      2'b00: begin
        round_inc  = g_reg & (r_reg | s_reg | z_m_reg[0]);
        ovf_to_inf = 1'b1;
      end
      2'b01: begin
        round_inc  = 1'b0;
        ovf_to_inf = 1'b0;
      end
      2'b10: begin
        round_inc  = z_s_reg & (g_reg | r_reg | s_reg);
        ovf_to_inf = z_s_reg;
      end
      default: begin
        round_inc  = ~z_s_reg & (g_reg | r_reg | s_reg);
        ovf_to_inf = ~z_s_reg;
      end
    endcase
  end

  assign pack_tiny = (z_e_reg == E_MIN) && !z_m_reg[M-1];
  assign pack_exp  = pack_tiny ? '0 : EXP_W'(z_e_reg + E_MAX);
  assign inf_word  = {z_s_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  assign max_word  = {z_s_reg, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

  always_ff @(posedge clk) begin
    if (rst) state_reg <= GET_A;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      GET_A:   if (a_ack_reg && input_a_stb) state_next = GET_B;
      GET_B:   if (b_ack_reg && input_b_stb) state_next = UNPACK;
      UNPACK:  state_next = SPECIAL;
      SPECIAL: state_next = is_special ? PUT_Z : NORM_A;
      NORM_A:  if (a_m_reg[M-1]) state_next = NORM_B;
      NORM_B:  if (b_m_reg[M-1]) state_next = MUL_0;
      MUL_0:   state_next = MUL_1;
      MUL_1:   state_next = NORM_1;
      NORM_1:  if (z_m_reg[M-1]) state_next = NORM_2;
      NORM_2:  if (z_e_reg >= E_MIN) state_next = ROUND;
      ROUND:   state_next = PACK;
      PACK:    state_next = PUT_Z;
      PUT_Z:   if (z_stb_reg && output_z_ack) state_next = GET_A;
      default: state_next = GET_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_ack_reg <= 1'b0;
      b_ack_reg <= 1'b0;
      z_stb_reg <= 1'b0;
      z_reg     <= '0;
      flags_reg <= '0;
    end else begin
      case (state_reg)
        GET_A: begin
          a_ack_reg <= 1'b1;
          if (a_ack_reg && input_a_stb) begin
            a_reg     <= input_a;
            rm_reg    <= input_rm;
            a_ack_reg <= 1'b0;
          end
        end
        GET_B: begin
          b_ack_reg <= 1'b1;
          if (b_ack_reg && input_b_stb) begin
            b_reg     <= input_b;
            b_ack_reg <= 1'b0;
          end
        end
        UNPACK: begin
          a_m_reg <= {1'b0, op_frac[0]};
          b_m_reg <= {1'b0, op_frac[1]};
          a_e_reg <= $signed({2'b00, op_exp[0]}) - E_MAX;
          b_e_reg <= $signed({2'b00, op_exp[1]}) - E_MAX;
        end
        SPECIAL: begin
          if (|op_nan) begin
            z_reg     <= QNAN;
            flags_reg <= {|op_snan, 3'b000};
          end else if ((op_inf[0] && op_zero[1]) || (op_zero[0] && op_inf[1])) begin
            z_reg     <= QNAN;
            flags_reg <= 4'b1000;
          end else if (|op_inf) begin
            z_reg     <= {z_sign_w, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_reg <= 4'b0000;
          end else if (|op_zero) begin
            z_reg     <= {z_sign_w, {(W-1){1'b0}}};
            flags_reg <= 4'b0000;
          end else begin
            // Subnormals keep a zero hidden bit and the minimum exponent
            if (op_sub[0]) a_e_reg <= E_MIN;
            else           a_m_reg[M-1] <= 1'b1;
            if (op_sub[1]) b_e_reg <= E_MIN;
            else           b_m_reg[M-1] <= 1'b1;
          end
        end
        NORM_A: if (!a_m_reg[M-1]) begin
          a_m_reg <= a_m_reg << 1;
          a_e_reg <= a_e_reg - E_ONE;
        end
        NORM_B: if (!b_m_reg[M-1]) begin
          b_m_reg <= b_m_reg << 1;
          b_e_reg <= b_e_reg - E_ONE;
        end
        MUL_0: begin
          z_s_reg  <= a_reg[W-1] ^ b_reg[W-1];
          z_e_reg  <= a_e_reg + b_e_reg + E_ONE;
          prod_reg <= a_m_reg * b_m_reg;
        end
        MUL_1: begin
          z_m_reg <= prod_reg[2*M-1:M];
          g_reg   <= prod_reg[M-1];
          r_reg   <= prod_reg[M-2];
          s_reg   <= |prod_reg[M-3:0];
        end
        NORM_1: if (!z_m_reg[M-1]) begin
          z_m_reg <= {z_m_reg[M-2:0], g_reg};
          z_e_reg <= z_e_reg - E_ONE;
          g_reg   <= r_reg;
          r_reg   <= 1'b0;
        end
        NORM_2: if (z_e_reg < E_MIN) begin
          z_m_reg <= z_m_reg >> 1;
          z_e_reg <= z_e_reg + E_ONE;
          g_reg   <= z_m_reg[0];
          r_reg   <= g_reg;
          s_reg   <= s_reg | r_reg;
        end
        ROUND: begin
          inexact_reg <= g_reg | r_reg | s_reg;
          if (round_inc) begin
            if (&z_m_reg) begin
              z_m_reg <= {1'b1, {(M-1){1'b0}}};
              z_e_reg <= z_e_reg + E_ONE;
            end else begin
              z_m_reg <= z_m_reg + 1'b1;
            end
          end
        end
        PACK: begin
          if (z_e_reg > E_MAX) begin
            z_reg     <= ovf_to_inf ? inf_word : max_word;
            flags_reg <= 4'b0101;
          end else begin
            z_reg     <= {z_s_reg, pack_exp, z_m_reg[M-2:0]};
            flags_reg <= {2'b00, inexact_reg & pack_tiny, inexact_reg};
          end
        end
        PUT_Z: begin
          z_stb_reg <= 1'b1;
          if (z_stb_reg && output_z_ack) z_stb_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign input_a_ack  = a_ack_reg;
  assign input_b_ack  = b_ack_reg;
  assign output_z     = z_reg;
  assign output_z_stb = z_stb_reg;
  assign output_flags = flags_reg;

endmodule

// File: tb/tb_fp_mul_param.sv
// tb_fp_mul_param: directed checks of the FP32 multiplier (plus one binary16 build)
// covering specials, rounding, overflow, subnormals, backpressure and reset.
module tb_fp_mul_param;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  input_rm;
  logic [31:0] a_in, b_in, z_out;
  logic        a_stb, a_ack, b_stb, b_ack, z_stb, z_ack;
  logic [3:0]  flags;
  logic [15:0] h_a, h_b, h_z;
  logic        h_a_stb, h_a_ack, h_b_stb, h_b_ack, h_z_stb, h_z_ack;
  logic [3:0]  h_flags;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_mul_param dut (
    .clk(clk), .rst(rst),
    .input_a(a_in), .input_a_stb(a_stb), .input_a_ack(a_ack), .input_rm(input_rm),
    .input_b(b_in), .input_b_stb(b_stb), .input_b_ack(b_ack),
    .output_z(z_out), .output_z_stb(z_stb), .output_z_ack(z_ack), .output_flags(flags)
  );

  fp_mul_param #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clk(clk), .rst(rst),
    .input_a(h_a), .input_a_stb(h_a_stb), .input_a_ack(h_a_ack), .input_rm(input_rm),
    .input_b(h_b), .input_b_stb(h_b_stb), .input_b_ack(h_b_ack),
    .output_z(h_z), .output_z_stb(h_z_stb), .output_z_ack(h_z_ack), .output_flags(h_flags)
  );

  // Hand A then B over; returns #1 after the B-accept edge. rm is scrambled after
  // the A accept, since only the A-accept edge may sample it.
  task automatic send_ab(input bit h, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] rm);
    int t;
    @(negedge clk);
    if (h) begin h_a = a[15:0]; h_a_stb = 1'b1; end
    else   begin a_in = a; a_stb = 1'b1; end
    input_rm = rm;
    t = 0;
    while (!(h ? h_a_ack : a_ack) && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin
      checks++; failures++;
      $display("FAIL a_ack_timeout: got no ack after %0d cycles, required ack", t);
    end
    @(posedge clk); #1;
    h_a_stb = 1'b0; a_stb = 1'b0;
    input_rm = ~rm;
    if (h) begin h_b = b[15:0]; h_b_stb = 1'b1; end
    else   begin b_in = b; b_stb = 1'b1; end
    t = 0;
    @(negedge clk);
    while (!(h ? h_b_ack : b_ack) && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin
      checks++; failures++;
      $display("FAIL b_ack_timeout: got no ack after %0d cycles, required ack", t);
    end
    @(posedge clk); #1;
    h_b_stb = 1'b0; b_stb = 1'b0;
  endtask

  // Runs one operation up to the result strobe; lat counts edges after the B accept.
  task automatic start_op(input bit h, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] rm, output logic [31:0] z,
                          output logic [3:0] fl, output int lat);
    send_ab(h, a, b, rm);
    lat = 0;
    while (!(h ? h_z_stb : z_stb) && lat < 600) begin @(posedge clk); #1; lat++; end
    if (lat >= 600) begin
      checks++; failures++;
      $display("FAIL z_stb_timeout: got no strobe after %0d cycles, required strobe", lat);
    end
    z  = h ? {16'h0000, h_z} : z_out;
    fl = h ? h_flags : flags;
    $display("op a=%h b=%h rm=%0d -> z=%h flags=%b lat=%0d", a, b, rm, z, fl, lat);
  endtask

  task automatic finish_op(input bit h);
    @(negedge clk);
    if (h) h_z_ack = 1'b1; else z_ack = 1'b1;
    @(posedge clk); #1;
    h_z_ack = 1'b0; z_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (a_ack !== 1'b0) begin failures++; $display("FAIL reset_a_ack: got %b required 0", a_ack); end
    checks++; if (b_ack !== 1'b0) begin failures++; $display("FAIL reset_b_ack: got %b required 0", b_ack); end
    checks++; if (z_stb !== 1'b0) begin failures++; $display("FAIL reset_z_stb: got %b required 0", z_stb); end
    checks++; if (z_out !== 32'h0) begin failures++; $display("FAIL reset_z: got %h required 0", z_out); end
    checks++; if (flags !== 4'h0) begin failures++; $display("FAIL reset_flags: got %b required 0000", flags); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (a_ack !== 1'b1) begin failures++; $display("FAIL reset_first_ack: got %b required 1", a_ack); end
    $display("reset released, a_ack=%b", a_ack);
  endtask

  task automatic test_basic();
    logic [31:0] z; logic [3:0] fl; int lat;
    // 1.5 x 1.0 leaves the product MSB clear, so NORM_1 shifts once: 11 + 1 cycles
    start_op(0, 32'h40400000, 32'h40000000, 2'b00, z, fl, lat);
    finish_op(0);
    checks++; if (z !== 32'h40C00000) begin failures++; $display("FAIL basic_3x2_z: got %h required 40c00000", z); end
    checks++; if (fl !== 4'b0000) begin failures++; $display("FAIL basic_3x2_flags: got %b required 0000", fl); end
    checks++; if (lat !== 12) begin failures++; $display("FAIL basic_3x2_latency: got %0d required 12", lat); end
    // 1.5 x 1.5 = 2.25 sets the product MSB: base latency
    start_op(0, 32'h3FC00000, 32'h3FC00000, 2'b00, z, fl, lat);
    finish_op(0);
    checks++; if (z !== 32'h40100000) begin failures++; $display("FAIL basic_2p25_z: got %h required 40100000", z); end
    checks++; if (lat !== 11) begin failures++; $display("FAIL basic_2p25_latency: got %0d required 11", lat); end
  endtask

  task automatic test_special();
    logic [31:0] va [5], vb [5], vz [5];
    logic [3:0]  vf [5];
    logic [31:0] z; logic [3:0] fl; int lat;
    va = '{32'h7F800000, 32'h7F800001, 32'h7FC00001, 32'h80000000, 32'hFF800000};
    vb = '{32'h00000000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000};
    vz = '{32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h80000000, 32'hFF800000};
    vf = '{4'b1000,      4'b1000,      4'b0000,      4'b0000,      4'b0000};
    for (int i = 0; i < 5; i++) begin
      start_op(0, va[i], vb[i], 2'b00, z, fl, lat);
      finish_op(0);
      checks++; if (z !== vz[i]) begin failures++; $display("FAIL special%0d_z: got %h required %h", i, z, vz[i]); end
      checks++; if (fl !== vf[i]) begin failures++; $display("FAIL special%0d_flags: got %b required %b", i, fl, vf[i]); end
      checks++; if (lat !== 3) begin failures++; $display("FAIL special%0d_latency: got %0d required 3", i, lat); end
    end
  endtask

  task automatic test_rounding();
    logic [1:0]  vrm [3];
    logic [31:0] vz [3];
    logic [31:0] z; logic [3:0] fl; int lat;
    vrm = '{2'b00, 2'b01, 2'b11};
    vz  = '{32'h3F800002, 32'h3F800002, 32'h3F800003};
    for (int i = 0; i < 3; i++) begin
      start_op(0, 32'h3F800001, 32'h3F800001, vrm[i], z, fl, lat);
      finish_op(0);
      checks++; if (z !== vz[i]) begin failures++; $display("FAIL round_rm%0d_z: got %h required %h", vrm[i], z, vz[i]); end
      checks++; if (fl !== 4'b0001) begin failures++; $display("FAIL round_rm%0d_flags: got %b required 0001", vrm[i], fl); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] va [4], vz [4];
    logic [1:0]  vrm [4];
    logic [31:0] z; logic [3:0] fl; int lat;
    va  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'hFF7FFFFF};
    vrm = '{2'b00,        2'b01,        2'b10,        2'b11};
    vz  = '{32'h7F800000, 32'h7F7FFFFF, 32'hFF800000, 32'hFF7FFFFF};
    for (int i = 0; i < 4; i++) begin
      start_op(0, va[i], 32'h40000000, vrm[i], z, fl, lat);
      finish_op(0);
      checks++; if (z !== vz[i]) begin failures++; $display("FAIL ovf%0d_z: got %h required %h", i, z, vz[i]); end
      checks++; if (fl !== 4'b0101) begin failures++; $display("FAIL ovf%0d_flags: got %b required 0101", i, fl); end
    end
  endtask

  task automatic test_subnormal();
    logic [31:0] z; logic [3:0] fl; int lat;
    start_op(0, 32'h00800000, 32'h3F000000, 2'b00, z, fl, lat);
    finish_op(0);
    checks++; if (z !== 32'h00400000) begin failures++; $display("FAIL sub_half_min_z: got %h required 00400000", z); end
    checks++; if (fl !== 4'b0000) begin failures++; $display("FAIL sub_half_min_flags: got %b required 0000", fl); end
    start_op(0, 32'h00000001, 32'h3F000000, 2'b00, z, fl, lat);
    finish_op(0);
    checks++; if (z !== 32'h00000000) begin failures++; $display("FAIL sub_tiny_z: got %h required 00000000", z); end
    checks++; if (fl !== 4'b0011) begin failures++; $display("FAIL sub_tiny_flags: got %b required 0011", fl); end
  endtask

  task automatic test_half();
    logic [31:0] z; logic [3:0] fl; int lat;
    start_op(1, 32'h3C00, 32'hC000, 2'b00, z, fl, lat);
    finish_op(1);
    checks++; if (z[15:0] !== 16'hC000) begin failures++; $display("FAIL half_z: got %h required c000", z[15:0]); end
    checks++; if (fl !== 4'b0000) begin failures++; $display("FAIL half_flags: got %b required 0000", fl); end
  endtask

  task automatic test_backpressure();
    logic [31:0] z; logic [3:0] fl; int lat;
    start_op(0, 32'h40400000, 32'h40000000, 2'b00, z, fl, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (z_stb !== 1'b1) begin failures++; $display("FAIL hold%0d_stb: got %b required 1", i, z_stb); end
      checks++; if (z_out !== 32'h40C00000) begin failures++; $display("FAIL hold%0d_z: got %h required 40c00000", i, z_out); end
    end
    finish_op(0);
    @(posedge clk); #1;
    checks++; if (z_stb !== 1'b0) begin failures++; $display("FAIL hold_release_stb: got %b required 0", z_stb); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] z; logic [3:0] fl; int lat;
    send_ab(0, 32'h40400000, 32'h40000000, 2'b00);
    repeat (6) @(posedge clk);   // now in NORM_1
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (a_ack !== 1'b0) begin failures++; $display("FAIL midrst_ack_low: got %b required 0", a_ack); end
    @(posedge clk); #1;
    checks++; if (a_ack !== 1'b1) begin failures++; $display("FAIL midrst_ack_rise: got %b required 1", a_ack); end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (z_stb !== 1'b0) begin
        checks++; failures++;
        $display("FAIL midrst_no_result: got stb %b at cycle %0d required 0", z_stb, i);
        break;
      end
    end
    checks++; if (z_out !== 32'h0) begin failures++; $display("FAIL midrst_z: got %h required 00000000", z_out); end
    start_op(0, 32'h3F800000, 32'h3F800000, 2'b01, z, fl, lat);
    finish_op(0);
    checks++; if (z !== 32'h3F800000) begin failures++; $display("FAIL midrst_recover_z: got %h required 3f800000", z); end
  endtask

  initial begin
    a_in = '0; b_in = '0; a_stb = 1'b0; b_stb = 1'b0; z_ack = 1'b0;
    h_a = '0; h_b = '0; h_a_stb = 1'b0; h_b_stb = 1'b0; h_z_ack = 1'b0;
    input_rm = 2'b00;
    test_reset();
    test_basic();
    test_special();
    test_rounding();
    test_overflow();
    test_subnormal();
    test_half();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
